// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transfer sequencer: FSM encoding and byte constants.
package spi_pkg;

  localparam int C_BYTE_W = 8;
  localparam logic [C_BYTE_W-1:0] C_FILL_BYTE_DEF = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    WAIT  = 2'b01,
    STORE = 2'b11
  } xfer_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous byte FIFO, 2**AW entries, first-word-fall-through head, flush clears pointers.
module spi_sync_fifo
  import spi_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic                Bus2IP_Clk,
  input  logic                Bus2IP_Reset,
  input  logic                flush,
  input  logic                push,
  input  logic [C_BYTE_W-1:0] din,
  input  logic                pop,
  output logic [C_BYTE_W-1:0] dout,
  output logic                full,
  output logic                empty
);

  localparam int DEPTH = 1 << AW;

  logic [C_BYTE_W-1:0] mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                do_push;
  logic                do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/spi_xfer_sequencer.sv
// Byte-stream front end for the SPI shifter: TX/RX FIFOs, fill-byte bursts and a
// one-in-flight start/done handshake with busy/done_irq reporting.
module spi_xfer_sequencer
  import spi_pkg::*;
#(
  parameter int                  C_FIFO_AW   = 4,
  parameter logic [C_BYTE_W-1:0] C_FILL_BYTE = C_FILL_BYTE_DEF,
  parameter int                  C_CNT_W     = 16
) (
  input  logic                Bus2IP_Clk,
  input  logic                Bus2IP_Reset,
  input  logic                tx_wr,
  input  logic [C_BYTE_W-1:0] tx_data,
  output logic                tx_full,
  input  logic                rx_rd,
  output logic [C_BYTE_W-1:0] rx_data,
  output logic                rx_empty,
  input  logic                rx_discard,
  input  logic                fill_load,
  input  logic [C_CNT_W-1:0]  fill_len,
  input  logic                flush,
  output logic                busy,
  output logic                done_irq,
  output logic                xfer_start,
  output logic [C_BYTE_W-1:0] xfer_tx,
  input  logic                xfer_busy,
  input  logic                xfer_done,
  input  logic [C_BYTE_W-1:0] xfer_rx
);

  xfer_state_t         state;
  xfer_state_t         state_nxt;
  logic [C_CNT_W-1:0]  fill_cnt;
  logic [C_BYTE_W-1:0] tx_head;
  logic                tx_empty;
  logic                tx_pop;
  logic                rx_full;
  logic                rx_push;
  logic                src_ok;
  logic                use_tx;
  logic                start;
  logic                busy_q;
  logic                irq_mask;

  spi_sync_fifo #(.AW(C_FIFO_AW)) u_tx_fifo (
    .Bus2IP_Clk   (Bus2IP_Clk),
    .Bus2IP_Reset (Bus2IP_Reset),
    .flush        (flush),
    .push         (tx_wr),
    .din          (tx_data),
    .pop          (tx_pop),
    .dout         (tx_head),
    .full         (tx_full),
    .empty        (tx_empty)
  );

  spi_sync_fifo #(.AW(C_FIFO_AW)) u_rx_fifo (
    .Bus2IP_Clk   (Bus2IP_Clk),
    .Bus2IP_Reset (Bus2IP_Reset),
    .flush        (flush),
    .push         (rx_push),
    .din          (xfer_rx),
    .pop          (rx_rd),
    .dout         (rx_data),
    .full         (rx_full),
    .empty        (rx_empty)
  );

  assign use_tx  = ~tx_empty;
  assign src_ok  = use_tx | (fill_cnt != '0);
  assign tx_pop  = start & use_tx;
  assign rx_push = (state == WAIT) & xfer_done & ~rx_discard;
  assign busy    = (state != IDLE) | ~tx_empty | (fill_cnt != '0);
  assign done_irq = busy_q & ~busy & ~irq_mask;

  // Starting only with RX space guarantees the completed byte always fits.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    case (state)
      IDLE: begin
        if (~flush & ~xfer_busy & (rx_discard | ~rx_full) & src_ok) begin
          start     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT:    if (xfer_done) state_nxt = STORE;
      STORE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Bus2IP_Clk) begin
    if (Bus2IP_Reset) begin
      state      <= IDLE;
      xfer_start <= 1'b0;
      xfer_tx    <= '0;
      fill_cnt   <= '0;
      busy_q     <= 1'b0;
      irq_mask   <= 1'b0;
    end else begin
      state      <= state_nxt;
      xfer_start <= start;
      busy_q     <= busy;
      if (start) xfer_tx <= use_tx ? tx_head : C_FILL_BYTE;
      if (flush)                 fill_cnt <= '0;
      else if (fill_load)        fill_cnt <= fill_len;
      else if (start & ~use_tx)  fill_cnt <= fill_cnt - 1'b1;
      // A flush hides the busy fall it causes; fresh host work re-arms the interrupt.
      if (flush)                          irq_mask <= 1'b1;
      else if (tx_wr | fill_load | ~busy) irq_mask <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// Randomized bench for spi_xfer_sequencer with a looping-back shifter model and a
// queue-based reference of the byte order, RX contents and interrupt count.
`timescale 1ns/1ps
module tb_spi_xfer_sequencer;

  localparam int CW = 16;

  logic          Bus2IP_Clk = 1'b0;
  logic          Bus2IP_Reset;
  logic          tx_wr;
  logic [7:0]    tx_data;
  logic          tx_full;
  logic          rx_rd;
  logic [7:0]    rx_data;
  logic          rx_empty;
  logic          rx_discard;
  logic          fill_load;
  logic [CW-1:0] fill_len;
  logic          flush;
  logic          busy;
  logic          done_irq;
  logic          xfer_start;
  logic [7:0]    xfer_tx;
  logic          xfer_busy;
  logic          xfer_done;
  logic [7:0]    xfer_rx;

  always #5 Bus2IP_Clk = ~Bus2IP_Clk;

  spi_xfer_sequencer dut (
    .Bus2IP_Clk   (Bus2IP_Clk),
    .Bus2IP_Reset (Bus2IP_Reset),
    .tx_wr        (tx_wr),
    .tx_data      (tx_data),
    .tx_full      (tx_full),
    .rx_rd        (rx_rd),
    .rx_data      (rx_data),
    .rx_empty     (rx_empty),
    .rx_discard   (rx_discard),
    .fill_load    (fill_load),
    .fill_len     (fill_len),
    .flush        (flush),
    .busy         (busy),
    .done_irq     (done_irq),
    .xfer_start   (xfer_start),
    .xfer_tx      (xfer_tx),
    .xfer_busy    (xfer_busy),
    .xfer_done    (xfer_done),
    .xfer_rx      (xfer_rx)
  );

  int         n_chk = 0;
  int         n_err = 0;
  int         n_start = 0;
  int         n_irq = 0;
  int         pend_cnt = 0;
  int         shf_dly = 0;
  int         m_txocc = 0;
  bit         m_disc = 0;
  logic       hold = 1'b0;
  logic [7:0] rx_xor = 8'h00;
  logic [7:0] pend_b;
  logic [7:0] obs_tx[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  // Shifter model: answers each start with a done pulse after a delay, looping back tx^rx_xor.
  initial begin
    xfer_busy = 1'b0;
    xfer_done = 1'b0;
    xfer_rx   = 8'h00;
    forever begin
      @(posedge Bus2IP_Clk); #1;
      xfer_done = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          xfer_done = 1'b1;
          xfer_rx   = pend_b ^ rx_xor;
        end
      end
      if (xfer_start === 1'b1) begin
        obs_tx.push_back(xfer_tx);
        n_start++;
        pend_b   = xfer_tx;
        pend_cnt = (shf_dly == 0) ? int'($urandom_range(1, 4)) : shf_dly;
      end
      xfer_busy = hold | (pend_cnt > 0);
    end
  end

  always @(negedge Bus2IP_Clk) if (done_irq === 1'b1) n_irq++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Bus2IP_Clk); #1;
  endtask

  task automatic set_hold(input logic v);
    hold = v;
    tick();
  endtask

  task automatic m_send(input logic [7:0] b);
    exp_tx.push_back(b);
    if (!m_disc) exp_rx.push_back(b ^ rx_xor);
  endtask

  task automatic m_tx(input logic [7:0] b);
    if (m_txocc < 16) begin
      m_send(b);
      m_txocc++;
    end
  endtask

  task automatic m_fill(input int n);
    for (int i = 0; i < n; i++) m_send(8'hFF);
  endtask

  task automatic wr_tx(input logic [7:0] b);
    tx_wr = 1'b1; tx_data = b;
    tick();
    tx_wr = 1'b0;
    m_tx(b);
  endtask

  task automatic ld_fill(input int n);
    fill_load = 1'b1; fill_len = CW'(n);
    tick();
    fill_load = 1'b0;
    m_fill(n);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i = 0;
    while (i < budget && (busy !== 1'b0 || pend_cnt != 0 || xfer_done)) begin
      tick();
      i++;
    end
    chk({tag, "_idle"}, 32'(i < budget), 32'd1);
    tick(); tick();
    m_txocc = 0;
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    int i = 0;
    while (i < budget && n_start < target) begin
      tick();
      i++;
    end
    chk({tag, "_starts"}, 32'(n_start >= target), 32'd1);
  endtask

  task automatic rd_rx(input string tag);
    logic [7:0] b;
    b = exp_rx.pop_front();
    chk({tag, "_rxne"}, 32'(rx_empty), 32'd0);
    chk({tag, "_rx"}, 32'(rx_data), 32'(b));
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
  endtask

  task automatic cmp_and_drain(input string tag);
    chk({tag, "_ntx"}, 32'(obs_tx.size()), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
      chk({tag, "_tx"}, 32'(obs_tx[i]), 32'(exp_tx[i]));
    obs_tx.delete();
    exp_tx.delete();
    while (exp_rx.size() > 0) rd_rx(tag);
    chk({tag, "_rxe"}, 32'(rx_empty), 32'd1);
  endtask

  initial begin
    int irq0, s0, nb, nf;
    Bus2IP_Reset = 1'b1;
    tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0; rx_discard = 1'b0;
    fill_load = 1'b0; fill_len = '0; flush = 1'b0;
    repeat (3) tick();
    chk("rst_start", 32'(xfer_start), 32'd0);
    chk("rst_xtx",   32'(xfer_tx), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_irq",   32'(done_irq), 32'd0);
    chk("rst_full",  32'(tx_full), 32'd0);
    chk("rst_empty", 32'(rx_empty), 32'd1);
    Bus2IP_Reset = 1'b0;
    tick();

    // Two looped-back host bytes
    m_disc = 0; rx_xor = 8'h00; irq0 = n_irq;
    wr_tx(8'hA5);
    wr_tx(8'h3C);
    wait_idle("two", 100);
    chk("two_irq", 32'(n_irq - irq0), 32'd1);
    cmp_and_drain("two");

    // Fill burst of three, received bytes discarded
    rx_discard = 1'b1; m_disc = 1; irq0 = n_irq;
    ld_fill(3);
    chk("fill_busy", 32'(busy), 32'd1);
    wait_idle("fill", 100);
    chk("fill_irq", 32'(n_irq - irq0), 32'd1);
    cmp_and_drain("fill");

    // TX bytes precede a fill loaded in the same cycle as the last write
    set_hold(1'b1);
    irq0 = n_irq;
    wr_tx(8'($urandom));
    tx_wr = 1'b1; tx_data = 8'($urandom); fill_load = 1'b1; fill_len = CW'(2);
    tick();
    tx_wr = 1'b0; fill_load = 1'b0;
    m_tx(tx_data);
    m_fill(2);
    set_hold(1'b0);
    wait_idle("order", 100);
    chk("order_irq", 32'(n_irq - irq0), 32'd1);
    cmp_and_drain("order");

    // TX full at 16 entries, RX full withholds the 17th transfer
    rx_discard = 1'b0; m_disc = 0; rx_xor = 8'($urandom);
    set_hold(1'b1);
    s0 = n_start;
    for (int i = 0; i < 17; i++) begin
      wr_tx(8'($urandom));
      if (i == 14) chk("txfull_15", 32'(tx_full), 32'd0);
      if (i == 15) chk("txfull_16", 32'(tx_full), 32'd1);
    end
    chk("txfull_17", 32'(tx_full), 32'd1);
    set_hold(1'b0);
    wait_starts("rxfull", s0 + 16, 300);
    repeat (10) tick();
    m_txocc = 0;
    wr_tx(8'($urandom));
    repeat (10) tick();
    chk("rxfull_held", 32'(n_start - s0), 32'd16);
    chk("rxfull_busy", 32'(busy), 32'd1);
    rd_rx("rxfull");
    wait_idle("rxfull", 100);
    chk("rxfull_after", 32'(n_start - s0), 32'd17);
    cmp_and_drain("rxfull");

    // Flush while a transfer is in flight
    shf_dly = 6; rx_xor = 8'($urandom);
    set_hold(1'b1);
    for (int i = 0; i < 6; i++) wr_tx(8'($urandom));
    while (exp_tx.size() > 1) void'(exp_tx.pop_back());
    while (exp_rx.size() > 1) void'(exp_rx.pop_back());
    s0 = n_start; irq0 = n_irq;
    set_hold(1'b0);
    wait_starts("flush", s0 + 1, 20);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd1);
    wait_idle("flush", 100);
    repeat (5) tick();
    chk("flush_nstart", 32'(n_start - s0), 32'd1);
    chk("flush_irq", 32'(n_irq - irq0), 32'd0);
    chk("flush_busy0", 32'(busy), 32'd0);
    cmp_and_drain("flush");

    // Reset during WAIT followed by a stray done
    s0 = n_start; irq0 = n_irq;
    wr_tx(8'h5A);
    wait_starts("rstw", s0 + 1, 20);
    Bus2IP_Reset = 1'b1;
    tick();
    Bus2IP_Reset = 1'b0;
    chk("rstw_busy",  32'(busy), 32'd0);
    chk("rstw_start", 32'(xfer_start), 32'd0);
    chk("rstw_xtx",   32'(xfer_tx), 32'd0);
    chk("rstw_full",  32'(tx_full), 32'd0);
    for (int i = 0; i < 20 && pend_cnt != 0; i++) tick();
    repeat (3) tick();
    chk("rstw_rxe",  32'(rx_empty), 32'd1);
    chk("rstw_busy2", 32'(busy), 32'd0);
    chk("rstw_irq",  32'(n_irq - irq0), 32'd0);
    chk("rstw_ns",   32'(n_start - s0), 32'd1);
    obs_tx.delete(); exp_tx.delete(); exp_rx.delete();
    m_txocc = 0;
    shf_dly = 0;

    // Random rounds of host bytes and fill bursts
    for (int r = 0; r < 20; r++) begin
      rx_discard = 1'($urandom);
      m_disc = rx_discard;
      rx_xor = 8'($urandom);
      nb = int'($urandom_range(0, 5));
      nf = int'($urandom_range(0, 4));
      irq0 = n_irq;
      set_hold(1'b1);
      for (int i = 0; i < nb; i++) wr_tx(8'($urandom));
      ld_fill(nf);
      set_hold(1'b0);
      wait_idle("rnd", 300);
      chk("rnd_irq", 32'(n_irq - irq0), 32'((nb + nf) > 0));
      cmp_and_drain("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
